// File: rtl/shift_issue_if.sv
// Handshake bundle between the shift issue unit and its neighbours.
// Carries three groups of signals:
//   in_*   upstream instruction offer (valid/ready)
//   sft_*  drive to, and result from, the combinational shifter
//   out_*  writeback drain (valid/ready) and the retired-instruction count
// The slave modport is used by shift_issue_unit. The master modport is used by
// the surrounding environment: upstream, shifter and writeback.
interface shift_issue_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_funct;
   logic [4:0]       in_shamt;
   logic [31:0]      in_rs;
   logic [31:0]      in_rt;

   logic             sft_left_right;
   logic [4:0]       sft_shamt;
   logic [31:0]      sft_src;
   logic [31:0]      sft_result;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_err;
   logic [CNT_W-1:0] retired_cnt;

   modport slave (
      input  in_valid, in_funct, in_shamt, in_rs, in_rt, sft_result, out_ready,
      output in_ready, sft_left_right, sft_shamt, sft_src,
             out_valid, out_result, out_err, retired_cnt
   );

   modport master (
      output in_valid, in_funct, in_shamt, in_rs, in_rt, sft_result, out_ready,
      input  in_ready, sft_left_right, sft_shamt, sft_src,
             out_valid, out_result, out_err, retired_cnt
   );
endinterface

// File: rtl/shift_issue_unit.sv
// Issue/retire stage around an external combinational shifter.
// An R-type shift instruction is decoded and held in a single issue
// register (S1), which drives the shifter. The shifter result is captured
// into a 2-entry output FIFO that drains to writeback.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  shift_issue_if.slave, carrying the in_*, sft_* and out_* groups
//        and retired_cnt
module shift_issue_unit #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_W      = 16
) (
   input logic          clk,
   input logic          rst,
   shift_issue_if.slave bus
);
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned OCC_W   = 2;

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] result;
   } entry_t;

   // S1 issue register
   logic               s1_valid_q, s1_valid_d;
   logic               s1_left_q,  s1_left_d;
   logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
   logic [DATA_W-1:0]  s1_src_q,   s1_src_d;
   logic               s1_err_q,   s1_err_d;

   // Output FIFO. The depth is fixed at 2, so each pointer is a single bit
   // that toggles.
   entry_t             fifo_mem_q [FIFO_DEPTH];
   entry_t             fifo_mem_d [FIFO_DEPTH];
   logic               head_q, head_d;
   logic               tail_q, tail_d;
   logic [OCC_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;

   logic               dec_left_c;
   logic [SHAMT_W-1:0] dec_shamt_c;
   logic               dec_err_c;
   logic               fifo_full_c;
   logic               in_ready_c;
   logic               accept_c;
   logic               retire_c;
   logic               pop_c;
   entry_t             push_entry_c;

   // Funct decode. Unsupported functs issue as a zero-amount right shift
   // with the error flag set.
   always_comb begin
      dec_left_c  = 1'b0;
      dec_shamt_c = '0;
      dec_err_c   = 1'b0;
      case (bus.in_funct)
         6'b000000: begin dec_left_c = 1'b1; dec_shamt_c = bus.in_shamt;   end
         6'b000010: begin dec_left_c = 1'b0; dec_shamt_c = bus.in_shamt;   end
         6'b000100: begin dec_left_c = 1'b1; dec_shamt_c = bus.in_rs[4:0]; end
         6'b000110: begin dec_left_c = 1'b0; dec_shamt_c = bus.in_rs[4:0]; end
         default:   dec_err_c = 1'b1;
      endcase
   end

   // Handshake decisions use the registered occupancy only, so out_ready
   // never reaches in_ready combinationally.
   always_comb begin
      fifo_full_c  = (count_q == OCC_W'(FIFO_DEPTH));
      in_ready_c   = !s1_valid_q || !fifo_full_c;
      accept_c     = bus.in_valid && in_ready_c;
      retire_c     = s1_valid_q && !fifo_full_c;
      pop_c        = (count_q != '0) && bus.out_ready;
      push_entry_c = '{err: s1_err_q, result: (s1_err_q ? '0 : bus.sft_result)};
   end

   // Next-state logic
   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_left_d     = s1_left_q;
      s1_shamt_d    = s1_shamt_q;
      s1_src_d      = s1_src_q;
      s1_err_d      = s1_err_q;
      fifo_mem_d    = fifo_mem_q;
      head_d        = head_q;
      tail_d        = tail_q;
      retired_cnt_d = retired_cnt_q;

      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_left_d  = dec_left_c;
         s1_shamt_d = dec_shamt_c;
         s1_src_d   = bus.in_rt;
         s1_err_d   = dec_err_c;
      end else if (retire_c) begin
         s1_valid_d = 1'b0;
      end

      if (retire_c) begin
         fifo_mem_d[tail_q] = push_entry_c;
         tail_d             = ~tail_q;
      end

      if (pop_c) begin
         head_d        = ~head_q;
         retired_cnt_d = retired_cnt_q + CNT_W'(1);
      end

      count_d = count_q + OCC_W'(retire_c) - OCC_W'(pop_c);
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_left_q     <= 1'b0;
         s1_shamt_q    <= '0;
         s1_src_q      <= '0;
         s1_err_q      <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_mem_q[i] <= '0;
         end
         head_q        <= 1'b0;
         tail_q        <= 1'b0;
         count_q       <= '0;
         retired_cnt_q <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_left_q     <= s1_left_d;
         s1_shamt_q    <= s1_shamt_d;
         s1_src_q      <= s1_src_d;
         s1_err_q      <= s1_err_d;
         fifo_mem_q    <= fifo_mem_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign bus.in_ready       = in_ready_c;
   assign bus.sft_left_right = s1_left_q;
   assign bus.sft_shamt      = s1_shamt_q;
   assign bus.sft_src        = s1_src_q;
   assign bus.out_valid      = (count_q != '0);
   assign bus.out_result     = fifo_mem_q[head_q].result;
   assign bus.out_err        = fifo_mem_q[head_q].err;
   assign bus.retired_cnt    = retired_cnt_q;

endmodule

// File: doc/shift_issue_unit.md
Name: shift_issue_unit

Overview:
Issue/retire stage wrapped around the combinational shifter. Accepts decoded R-type shift instructions over a valid/ready handshake and registers them. It drives the shifter's direction, amount and source from that register. The shifter result returns combinationally and is captured into a 2-entry output FIFO, which drains over a second valid/ready handshake to writeback.

Parameters:
FIFO_DEPTH, 2, output FIFO entries (fixed at 2; pointer logic assumes depth 2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream offers an instruction
in_ready  output  1  unit can accept this cycle
in_funct  input  6  R-type funct field
in_shamt  input  5  instruction shamt field
in_rs  input  32  rs register value (variable shift amount in bits [4:0])
in_rt  input  32  rt register value (shift source)
sft_left_right  output  1  to shifter: 1 = logical left, 0 = logical right
sft_shamt  output  5  to shifter: shift amount
sft_src  output  32  to shifter: source operand
sft_result  input  32  from shifter, combinational function of the three sft_* outputs
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_result  output  32  FIFO head result
out_err  output  1  FIFO head was an unsupported funct
retired_cnt  output  CNT_W  number of entries popped since reset

Behaviour:
- Decode of in_funct:
  - 000000 sll: left, shamt = in_shamt
  - 000010 srl: right, shamt = in_shamt
  - 000100 sllv: left, shamt = in_rs[4:0]
  - 000110 srlv: right, shamt = in_rs[4:0]
  - any other funct: err = 1, left = 0, shamt = 0
  - Source is always in_rt.
- Stage S1 register: s1_valid, s1_left, s1_shamt, s1_src, s1_err.
  - sft_* outputs are driven directly from S1 registers, with no combinational path from in_*.
- in_ready = !s1_valid || (fifo_count < 2). There is no combinational path from out_ready to in_ready.
- Accept: in_valid && in_ready loads S1 and sets s1_valid.
- S1 retire condition: s1_valid && fifo_count < 2. On retire, push {err ? 32'h0 : sft_result, s1_err} into the FIFO.
- S1 after retire:
  - If an accept happens in the same cycle, S1 is reloaded.
  - Otherwise s1_valid clears.
- Pop: out_valid && out_ready. Head advances and retired_cnt increments, wrapping at 2^CNT_W to 0.
- Simultaneous push and pop with count = 2: the push is not permitted, because the retire condition uses the registered count. The pop proceeds and the count becomes 1. Simultaneous push and pop with count 1 leaves the count unchanged.
- Latency: an instruction accepted at edge N is in S1 after N. It is pushed at edge N+1 and appears on out_valid in cycle N+1..N+2 (out_valid high after edge N+1) when the FIFO is empty.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Ordering: strict FIFO order. No entry is dropped or duplicated under any in_valid/out_ready pattern.
- out_result and out_err are stable while out_valid && !out_ready.
- Reset (asserted at any time, including mid-stream): s1_valid = 0, FIFO empty, pointers 0, retired_cnt = 0, all sft_* = 0, out_result = 0, out_err = 0, out_valid = 0. in_ready reads 1 while rst is high, and in-flight entries are discarded.
- shamt = 0 is legal and returns the source unchanged.

Test Plan:
- sll with in_rt=32'h0000_0001, in_shamt=31, out_ready=1 -> out_result=32'h8000_0000, out_err=0, out_valid exactly one edge after S1 load; retired_cnt=1.
- srlv with in_rt=32'hF000_0000, in_rs=32'hFFFF_FFE4 (shamt 4) -> out_result=32'h0F00_0000, sft_left_right=0, sft_shamt=4.
- Unsupported funct 000011 (sra) with in_rt=32'h8000_0000 -> out_result=0, out_err=1, ordering preserved relative to neighbours.
- out_ready=0, 4 back-to-back instructions offered:
  - accepts 3 (2 in FIFO, 1 in S1), then in_ready=0;
  - after out_ready=1, all 4 retire in order, no loss or duplication, retired_cnt=4.
- Random in_valid/out_ready (10k ops), compared against a reference model -> results match, FIFO order kept, fifo_count never exceeds 2.
- rst asserted asynchronously mid-stream with 2 entries queued -> out_valid drops immediately, retired_cnt=0. After release, the first new instruction returns the correct result.
